// File: rtl/ex_forward_ctrl_if.sv
// ex_forward_ctrl_if -- ID-stage instruction fields in, EX forwarding
// controls out.
//   master : the decode stage; drives the id_* fields and reads the controls.
//   slave  : ex_forward_ctrl; reads the id_* fields and drives
//            SelFwA/SelFwB/stall/ex_bubble.
interface ex_forward_ctrl_if #(
  parameter int REG_W = 4
);
  logic             id_valid;
  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             id_use1;
  logic             id_use2;
  logic [REG_W-1:0] id_rd;
  logic             id_regwrite;
  logic             id_memread;
  logic             id_vec;
  logic [1:0]       SelFwA;
  logic [1:0]       SelFwB;
  logic             stall;
  logic             ex_bubble;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use1, id_use2,
           id_rd, id_regwrite, id_memread, id_vec,
    input  SelFwA, SelFwB, stall, ex_bubble
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use1, id_use2,
           id_rd, id_regwrite, id_memread, id_vec,
    output SelFwA, SelFwB, stall, ex_bubble
  );
endinterface

// File: rtl/ex_forward_ctrl.sv
// ex_forward_ctrl -- forwarding and hazard control for a 5-stage pipe with
// a multi-cycle vector ALU in EX.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : ex_forward_ctrl_if.slave
//          id_*          instruction currently in ID
//          SelFwA/SelFwB registered EX operand selects
//                        (0 regfile, 1 EX/MEM, 2 MEM/WB, 3 retired-last)
//          stall         combinational; freezes PC and IF/ID, bubbles EX
//          ex_bubble     EX slot is empty

// Per-source forwarding select and load-use detect. One instance per source
// operand. Pipe index 0 = EX, 1 = MEM, 2 = WB.
module ex_fwd_src #(
  parameter int REG_W = 4
) (
  input  logic [REG_W-1:0]      src,
  input  logic                  use_src,
  input  logic [2:0]            vld,
  input  logic [2:0]            rw,
  input  logic [2:0][REG_W-1:0] rd,
  input  logic                  ex_memread,
  output logic [1:0]            sel,
  output logic                  load_use
);
  logic [2:0] hit;

  // r0 is hard-wired zero and never forwarded.
  always_comb begin
    for (int s = 0; s < 3; s++)
      hit[s] = vld[s] & rw[s] & (rd[s] == src) & (src != '0) & use_src;
  end

  // Youngest producer wins.
  always_comb begin
    sel = 2'd0;
    if      (hit[0]) sel = 2'd1;
    else if (hit[1]) sel = 2'd2;
    else if (hit[2]) sel = 2'd3;
  end

  assign load_use = hit[0] & ex_memread;
endmodule

module ex_forward_ctrl #(
  parameter int REG_W   = 4,
  parameter int VEC_LAT = 2   // 1..8
) (
  input  logic               clk,
  input  logic               rst,
  ex_forward_ctrl_if.slave   bus
);
  localparam int STAGES = 2;
  localparam int CNT_W  = 3;

  // Tracking pipe: [0]=EX, [1]=MEM, [2]=WB.
  logic [STAGES:0]            vld_pipe;
  logic [STAGES:0]            rw_pipe;
  logic [STAGES:0][REG_W-1:0] rd_pipe;
  // A load's result becomes forwardable once it leaves EX, so memread is
  // only ever consulted for the EX entry; older stages need not carry it.
  logic                       ex_memread;

  logic [CNT_W-1:0]           busy_cnt;
  logic [1:0]                 sel_a_q, sel_b_q;

  logic [1:0][REG_W-1:0]      src;
  logic [1:0]                 use_src;
  logic [1:0][1:0]            sel;
  logic [1:0]                 load_use;
  logic                       stall, issue;

  assign src     = {bus.id_rs2, bus.id_rs1};
  assign use_src = {bus.id_use2, bus.id_use1};

  for (genvar g = 0; g < 2; g++) begin : g_src
    ex_fwd_src #(.REG_W(REG_W)) u_src (
      .src        (src[g]),
      .use_src    (use_src[g]),
      .vld        (vld_pipe),
      .rw         (rw_pipe),
      .rd         (rd_pipe),
      .ex_memread (ex_memread),
      .sel        (sel[g]),
      .load_use   (load_use[g])
    );
  end

  // Load-use and vector-busy may coincide; one stall covers both and the
  // conditions are simply re-evaluated next cycle.
  assign stall = bus.id_valid & ((|load_use) | (busy_cnt != '0));
  assign issue = bus.id_valid & ~stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe   <= '0;
      rw_pipe    <= '0;
      rd_pipe    <= '0;
      ex_memread <= 1'b0;
      busy_cnt   <= '0;
      sel_a_q    <= 2'd0;
      sel_b_q    <= 2'd0;
    end else begin
      vld_pipe   <= {vld_pipe[STAGES-1:0], issue};
      rw_pipe    <= {rw_pipe[STAGES-1:0], issue & bus.id_regwrite};
      rd_pipe    <= {rd_pipe[STAGES-1:0], issue ? bus.id_rd : '0};
      ex_memread <= issue & bus.id_memread;
      // Selects are captured with the instruction; a bubble carries 0.
      sel_a_q    <= issue ? sel[0] : 2'd0;
      sel_b_q    <= issue ? sel[1] : 2'd0;
      // Vector op holds EX for VEC_LAT cycles: VEC_LAT-1 extra stall cycles.
      if (issue && bus.id_vec)
        busy_cnt <= CNT_W'(VEC_LAT - 1);
      else if (busy_cnt != '0)
        busy_cnt <= busy_cnt - 1'b1;
    end
  end

  assign bus.SelFwA    = sel_a_q;
  assign bus.SelFwB    = sel_b_q;
  assign bus.stall     = stall;
  assign bus.ex_bubble = ~vld_pipe[0];
endmodule

// File: tb/tb_ex_forward_ctrl.sv
// tb_ex_forward_ctrl -- scenario tasks for ex_forward_ctrl (VEC_LAT=3).
// Each cycle the expected EX outputs are queued when the ID instruction is
// driven, and popped and compared after the clock edge.
module tb_ex_forward_ctrl;
  localparam int REG_W   = 4;
  localparam int VEC_LAT = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_forward_ctrl_if #(.REG_W(REG_W)) bus ();

  ex_forward_ctrl #(.REG_W(REG_W), .VEC_LAT(VEC_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic       v;
    logic [3:0] rs1;
    logic       u1;
    logic [3:0] rs2;
    logic       u2;
    logic [3:0] rd;
    logic       rw;
    logic       mr;
    logic       vec;
  } ins_t;

  typedef struct packed {
    logic [1:0] a;
    logic [1:0] b;
    logic       bub;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic ins_t mk(input logic [3:0] rd, input logic rw,
                              input logic [3:0] rs1, input logic u1,
                              input logic [3:0] rs2, input logic u2,
                              input logic mr, input logic vec);
    ins_t i;
    i.v = 1'b1; i.rd = rd; i.rw = rw; i.rs1 = rs1; i.u1 = u1;
    i.rs2 = rs2; i.u2 = u2; i.mr = mr; i.vec = vec;
    return i;
  endfunction

  function automatic ins_t nop();
    return '0;
  endfunction

  task automatic drive(input ins_t i);
    bus.id_valid    = i.v;
    bus.id_rs1      = i.rs1;
    bus.id_rs2      = i.rs2;
    bus.id_use1     = i.u1;
    bus.id_use2     = i.u2;
    bus.id_rd       = i.rd;
    bus.id_regwrite = i.rw;
    bus.id_memread  = i.mr;
    bus.id_vec      = i.vec;
  endtask

  // One clock: present i in ID, check stall, then check the EX outputs
  // produced by the edge.
  task automatic cyc(input ins_t i, input logic exp_stall,
                     input logic [1:0] ea, input logic [1:0] eb,
                     input string name);
    exp_t e, got;
    logic iss;
    drive(i);
    #1;
    checks++;
    if (bus.stall !== exp_stall) begin
      failures++;
      $display("FAIL %s stall: got %b expected %b", name, bus.stall, exp_stall);
    end
    iss   = i.v & ~exp_stall;
    e.a   = iss ? ea : 2'd0;
    e.b   = iss ? eb : 2'd0;
    e.bub = ~iss;
    sb.push_back(e);
    @(posedge clk);
    #1;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL %s scoreboard: empty queue", name);
    end else begin
      e   = sb.pop_front();
      got = {bus.SelFwA, bus.SelFwB, bus.ex_bubble};
      if (got !== e) begin
        failures++;
        $display("FAIL %s ex: got A=%0d B=%0d bub=%b expected A=%0d B=%0d bub=%b",
                 name, got.a, got.b, got.bub, e.a, e.b, e.bub);
      end
    end
  endtask

  task automatic flush();
    for (int k = 0; k < 3; k++) cyc(nop(), 1'b0, 2'd0, 2'd0, "flush");
  endtask

  task automatic check_reset_vals(input string name);
    checks++;
    if ({bus.stall, bus.SelFwA, bus.SelFwB, bus.ex_bubble} !== 6'b0_00_00_1) begin
      failures++;
      $display("FAIL %s: got stall=%b A=%0d B=%0d bub=%b expected stall=0 A=0 B=0 bub=1",
               name, bus.stall, bus.SelFwA, bus.SelFwB, bus.ex_bubble);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(mk(4'd3, 1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1));
    #2;
    check_reset_vals("reset_hold");
    @(posedge clk); #1;
    check_reset_vals("reset_edge");
    rst = 1'b0;
    drive(nop());
  endtask

  task automatic test_back_to_back();
    flush();
    cyc(mk(4'd3, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0), 1'b0, 2'd0, 2'd0, "b2b_i1");
    cyc(mk(4'd0, 1'b0, 4'd3, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0), 1'b0, 2'd1, 2'd0, "b2b_i2");
  endtask

  task automatic test_distance();
    for (int n = 1; n <= 3; n++) begin
      flush();
      cyc(mk(4'd5, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0), 1'b0, 2'd0, 2'd0, "dist_i1");
      for (int k = 0; k < n; k++) cyc(nop(), 1'b0, 2'd0, 2'd0, "dist_nop");
      cyc(mk(4'd0, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0), 1'b0, 2'd0,
          (n == 1) ? 2'd2 : (n == 2) ? 2'd3 : 2'd0, "dist_use");
    end
  endtask

  task automatic test_load_use();
    ins_t use7;
    flush();
    use7 = mk(4'd0, 1'b0, 4'd7, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    cyc(mk(4'd7, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0), 1'b0, 2'd0, 2'd0, "ld_load");
    cyc(use7, 1'b1, 2'd0, 2'd0, "ld_stall");
    cyc(use7, 1'b0, 2'd2, 2'd0, "ld_reissue");
    // Load two ahead: already out of EX, no stall.
    flush();
    cyc(mk(4'd9, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0), 1'b0, 2'd0, 2'd0, "ld2_load");
    cyc(nop(), 1'b0, 2'd0, 2'd0, "ld2_nop");
    cyc(mk(4'd0, 1'b0, 4'd0, 1'b0, 4'd9, 1'b1, 1'b0, 1'b0), 1'b0, 2'd0, 2'd2, "ld2_use");
  endtask

  task automatic test_r0_priority();
    flush();
    cyc(mk(4'd0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0), 1'b0, 2'd0, 2'd0, "r0_i1");
    cyc(mk(4'd0, 1'b0, 4'd0, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0), 1'b0, 2'd0, 2'd0, "r0_use");
    flush();
    cyc(mk(4'd4, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0), 1'b0, 2'd0, 2'd0, "pri_i1");
    cyc(mk(4'd4, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0), 1'b0, 2'd0, 2'd0, "pri_i2");
    // rs2 also names r4 but its use bit is clear.
    cyc(mk(4'd0, 1'b0, 4'd4, 1'b1, 4'd4, 1'b0, 1'b0, 1'b0), 1'b0, 2'd1, 2'd0, "pri_i3");
  endtask

  task automatic test_vector();
    ins_t ind;
    flush();
    ind = mk(4'd6, 1'b1, 4'd2, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    cyc(mk(4'd1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1), 1'b0, 2'd0, 2'd0, "vec_op");
    cyc(ind, 1'b1, 2'd0, 2'd0, "vec_stall1");
    cyc(ind, 1'b1, 2'd0, 2'd0, "vec_stall2");
    cyc(ind, 1'b0, 2'd0, 2'd0, "vec_issue");
    // Reset pulsed during a vector stall.
    flush();
    cyc(mk(4'd1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1), 1'b0, 2'd0, 2'd0, "vrst_op");
    cyc(ind, 1'b1, 2'd0, 2'd0, "vrst_stall");
    drive(ind);
    rst = 1'b1;
    #1;
    check_reset_vals("vrst_async");
    @(posedge clk); #1;
    check_reset_vals("vrst_edge");
    rst = 1'b0;
    // Depends on the vector op's rd: all tracking must be gone.
    cyc(mk(4'd0, 1'b0, 4'd1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0), 1'b0, 2'd0, 2'd0, "vrst_after");
  endtask

  initial begin
    drive(nop());
    test_reset();
    @(posedge clk); #1;
    test_back_to_back();
    test_distance();
    test_load_use();
    test_r0_priority();
    test_vector();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ex_forward_ctrl.md
EX_FORWARD_CTRL -- requirements
Module: ex_forward_ctrl

Interface
REQ-001 Parameter REG_W, default 4: register-index width, giving 16 architectural registers.
REQ-002 Parameter VEC_LAT, default 2: EX occupancy in cycles of a vector (multi-ALU) operation, range 1-8.
REQ-003 Port clk  input  1  rising-edge clock.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port id_valid  input  1  an instruction is present in ID.
REQ-006 Port id_rs1 / id_rs2  input  REG_W each  source register indices.
REQ-007 Port id_use1 / id_use2  input  1 each  the instruction reads rs1 / rs2.
REQ-008 Port id_rd  input  REG_W  destination register index.
REQ-009 Port id_regwrite  input  1  the instruction writes rd.
REQ-010 Port id_memread  input  1  the instruction is a load; its result is ready only at MEM exit.
REQ-011 Port id_vec  input  1  the instruction uses the vector ALU (ALU_Selector=1 in EX).
REQ-012 Port SelFwA / SelFwB  output  2 each  registered forwarding selects for the EX stage: 0 = register-file data, 1 = Fw1 (EX/MEM result), 2 = Fw2 (MEM/WB result), 3 = Fw3 (value retired one cycle before WB).
REQ-013 Port stall  output  1  combinational; holds PC and IF/ID and forces a bubble into EX.
REQ-014 Port ex_bubble  output  1  registered; the EX-stage slot holds no instruction.

Function
REQ-015 The block SHALL keep a 3-entry tracking pipe (EX, MEM, WB), each entry holding {valid, rd, regwrite, memread}.
REQ-016 Each cycle, MEM<-EX and WB<-MEM; EX<-ID fields if (id_valid && !stall), otherwise EX<-invalid.
REQ-017 A producer matches source s only when: the entry is valid, regwrite=1, rd==s, s!=0, and the matching use bit is 1.
REQ-018 Select for each source, computed against the pre-edge pipe, with youngest-first priority: EX match -> 1; else MEM match -> 2; else WB match -> 3; else 0.
REQ-019 SelFwA/SelFwB SHALL register the REQ-018 values on the edge where the instruction enters EX, and register 0 on any edge that inserts a bubble.
REQ-020 Load-use hazard: the EX entry matches a used source (REQ-017) and EX.memread=1.
REQ-021 busy_cnt: loads VEC_LAT-1 when a vector instruction issues; otherwise decrements by 1 when nonzero.
REQ-022 stall = id_valid && (load-use hazard || busy_cnt!=0); if both conditions hold, the block asserts one stall and re-evaluates both next cycle.
REQ-023 Load-use stall lasts exactly 1 cycle; on re-issue the load sits in MEM, so the select value is 2.
REQ-024 With VEC_LAT=1, a vector op never causes a stall.
REQ-025 id_valid=0 SHALL never assert stall; the EX entry becomes invalid.
REQ-026 ex_bubble = !EX.valid.

Reset
REQ-027 While rst is high: all valid bits = 0, busy_cnt = 0, SelFwA = SelFwB = 0, ex_bubble = 1, stall = 0.
REQ-028 Reset asserted mid-stall or mid-vector-op SHALL discard all tracking state immediately; the first instruction after release sees no hazards.

Verification
REQ-029 Back-to-back dependency: I1 rd=3 regwrite, then I2 rs1=3 use1 -> I2 enters EX with SelFwA=1, stall=0.
REQ-030 Distances 2 and 3: I1 rd=5, a NOP, then I3 rs2=5 -> SelFwB=2; with two NOPs between -> SelFwB=3; with three NOPs -> SelFwB=0.
REQ-031 Load-use: LD rd=7, then I2 rs1=7 -> stall=1 for one cycle and ex_bubble=1, then I2 enters EX with SelFwA=2.
REQ-032 Register 0 and priority: I1 rd=0 followed by a use of r0 -> Sel=0; I1 rd=4 and I2 rd=4 followed by I3 rs1=4 -> SelFwA=1 (I2 wins).
REQ-033 Vector busy (VEC_LAT=3): vector op issues, then an independent instruction -> stall=1 for 2 cycles, then it issues; rst pulsed during the stall -> stall=0 and all outputs at REQ-027 values.
